sync_bus_arbiter: RTL and testbench

Source-domain arbiter and sequencer for the multi-flop bus synchronizer. It shares one synchronizer data channel among `NUM_REQ` requesters using round-robin arbitration. For each granted word it drives `unsync_bus` and a level `bus_enable` with guaranteed stable-hold and idle-gap windows, so the destination side produces exactly one enable pulse and one clean `sync_bus` update per transfer. It sits in the sending clock domain, directly in front of the synchronizer's `unsync_bus`/`bus_enable` inputs.

---
 rtl/sync_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_sync_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_bus_arbiter.sv
// sync_bus_arbiter: round-robin arbiter and sequencer in front of a multi-flop
// bus synchronizer. Each granted word is driven on unsync_bus with bus_enable
// high for HOLD_CYCLES, followed by GAP_CYCLES of low enable before the next
// arbitration, so the destination sees one clean update per transfer.
module sync_bus_arbiter #(
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic [BUS_WIDTH-1:0]           unsync_bus,
  output logic                           bus_enable,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy
);

  localparam int unsigned IDW     = $clog2(NUM_REQ);
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e                  state_q;
  logic [IDW-1:0]          ptr_q;
  logic [CW-1:0]           cnt_q;
  logic [BUS_WIDTH-1:0]    bus_q;
  logic                    en_q;
  logic [NUM_REQ-1:0]      ack_q;
  logic [IDW-1:0]          gid_q;
  logic                    busy_q;

  logic [BUS_WIDTH-1:0]    words [NUM_REQ];
  logic                    pick_vld;
  logic [IDW-1:0]          grant_d;
  logic [IDW-1:0]          ptr_d;
  logic [BUS_WIDTH-1:0]    word_d;
  int unsigned             cand;

  // Split the flat request data bus into one word per requester
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      words[i] = req_data[i*BUS_WIDTH +: BUS_WIDTH];
    end
  end

  // Round-robin pick: first set request searching upward from ptr_q with wrap
  always_comb begin
    pick_vld = 1'b0;
    grant_d  = '0;
    ptr_d    = ptr_q;
    word_d   = '0;
    cand     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr_q) + k) % NUM_REQ;
      if (!pick_vld && req[IDW'(cand)]) begin
        pick_vld = 1'b1;
        grant_d  = IDW'(cand);
        word_d   = words[IDW'(cand)];
        ptr_d    = (cand == NUM_REQ - 1) ? '0 : IDW'(cand + 1);
      end
    end
  end

  // Transfer sequencer: IDLE -> HOLD -> GAP -> IDLE with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      bus_q   <= '0;
      en_q    <= 1'b0;
      ack_q   <= '0;
      gid_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            bus_q   <= word_d;
            en_q    <= 1'b1;
            gid_q   <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= HOLD_LOAD;
            busy_q  <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            en_q    <= 1'b0;
            ack_q   <= NUM_REQ'(1) << gid_q;
            cnt_q   <= GAP_LOAD;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        GAP: begin
          ack_q <= '0;
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          en_q    <= 1'b0;
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack        = ack_q;
  assign unsync_bus = bus_q;
  assign bus_enable = en_q;
  assign grant_id   = gid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sync_bus_arbiter.sv
// Bench for sync_bus_arbiter: vector table, directed corner sequences, and a
// randomized run against a transfer-timeline reference model.
`timescale 1ns/1ps
module tb_sync_bus_arbiter;

  localparam int BW = 8;
  localparam int NR = 4;
  localparam int H  = 4;
  localparam int G  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*BW-1:0]  req_data;
  logic [NR-1:0]     ack;
  logic [BW-1:0]     unsync_bus;
  logic              bus_enable;
  logic [1:0]        grant_id;
  logic              busy;

  logic [NR-1:0]     req_b;
  logic [NR*BW-1:0]  req_data_b;
  logic [NR-1:0]     ack_b;
  logic [BW-1:0]     unsync_bus_b;
  logic              bus_enable_b;
  logic [1:0]        grant_id_b;
  logic              busy_b;

  sync_bus_arbiter #(.BUS_WIDTH(BW), .NUM_REQ(NR), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .unsync_bus(unsync_bus), .bus_enable(bus_enable), .grant_id(grant_id), .busy(busy)
  );

  sync_bus_arbiter #(.BUS_WIDTH(BW), .NUM_REQ(NR), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_min (
    .clk(clk), .rst_n(rst_n), .req(req_b), .req_data(req_data_b), .ack(ack_b),
    .unsync_bus(unsync_bus_b), .bus_enable(bus_enable_b), .grant_id(grant_id_b), .busy(busy_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks elapsed cycles since the grant of the current transfer
  bit          model_on = 1'b0;
  bit          m_active;
  int          m_t;
  logic [7:0]  m_word;
  int          m_gid;
  int          m_ptr;

  task automatic model_reset();
    m_active = 1'b0;
    m_t      = 0;
    m_word   = '0;
    m_gid    = 0;
    m_ptr    = 0;
  endtask

  task automatic model_edge();
    if (m_active) begin
      m_t++;
      if (m_t >= H + G) m_active = 1'b0;
    end else if (req != '0) begin
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_ptr + k) % NR;
        if (req[idx]) begin
          m_gid = idx;
          break;
        end
      end
      m_word   = req_data[m_gid*BW +: BW];
      m_ptr    = (m_gid + 1) % NR;
      m_active = 1'b1;
      m_t      = 0;
    end
  endtask

  task automatic compare_model(input string tag);
    logic [31:0] e_ack;
    e_ack = (m_active && m_t == H) ? (32'd1 << m_gid) : 32'd0;
    check({tag, "_en"},   32'(bus_enable), 32'(m_active && m_t < H));
    check({tag, "_ack"},  32'(ack), e_ack);
    check({tag, "_busy"}, 32'(busy), 32'(m_active));
    check({tag, "_bus"},  32'(unsync_bus), 32'(m_word));
    check({tag, "_gid"},  32'(grant_id), m_gid);
  endtask

  task automatic step();
    @(posedge clk);
    if (model_on) begin
      if (!rst_n) model_reset();
      else        model_edge();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  rq;
    logic [31:0] data;
    int          gid;
    logic [7:0]  word;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] ack_seen [4];
    logic [7:0]    word_seen [4];
    int            cyc_seen [4];
    int            n_seen;
    int            order [8];
    int            exp_order [6];
    int            run, max_run;

    // ptr evolves 0,1,2,0,3,1,2,0 across these entries
    tbl[0] = '{4'b0001, 32'h000000A5, 0, 8'hA5};
    tbl[1] = '{4'b1010, 32'hFF005A00, 1, 8'h5A};
    tbl[2] = '{4'b1000, 32'hFF000000, 3, 8'hFF};
    tbl[3] = '{4'b0100, 32'h00BA0000, 2, 8'hBA};
    tbl[4] = '{4'b0011, 32'h00002211, 0, 8'h11};
    tbl[5] = '{4'b1111, 32'h44332211, 1, 8'h22};
    tbl[6] = '{4'b1001, 32'h9C0000C9, 3, 8'h9C};
    tbl[7] = '{4'b1110, 32'hE7D6C500, 1, 8'hC5};
    exp_order = '{0, 1, 2, 3, 0, 1};

    rst_n = 1'b0; req = '0; req_data = '0; req_b = '0; req_data_b = '0;
    repeat (2) @(negedge clk);

    check("rst_en",    32'(bus_enable), 0);
    check("rst_ack",   32'(ack), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_bus",   32'(unsync_bus), 0);
    check("rst_gid",   32'(grant_id), 0);
    check("rst_en_b",  32'(bus_enable_b), 0);
    check("rst_ack_b", 32'(ack_b), 0);
    rst_n = 1'b1;

    // Vector table: one complete transfer per entry, req withdrawn and data
    // scrambled right after the grant
    for (int e = 0; e < 8; e++) begin
      req = tbl[e].rq; req_data = tbl[e].data;
      step();
      check("tbl_grant_en",   32'(bus_enable), 1);
      check("tbl_grant_bus",  32'(unsync_bus), 32'(tbl[e].word));
      check("tbl_grant_gid",  32'(grant_id), tbl[e].gid);
      check("tbl_grant_busy", 32'(busy), 1);
      check("tbl_grant_ack",  32'(ack), 0);
      req = '0; req_data = '1;
      for (int i = 1; i < H; i++) begin
        step();
        check("tbl_hold_en",  32'(bus_enable), 1);
        check("tbl_hold_bus", 32'(unsync_bus), 32'(tbl[e].word));
        check("tbl_hold_ack", 32'(ack), 0);
      end
      step();
      check("tbl_ack",     32'(ack), 32'd1 << tbl[e].gid);
      check("tbl_ack_en",  32'(bus_enable), 0);
      check("tbl_ack_bus", 32'(unsync_bus), 32'(tbl[e].word));
      step();
      check("tbl_gap_ack",  32'(ack), 0);
      check("tbl_gap_busy", 32'(busy), 1);
      check("tbl_gap_en",   32'(bus_enable), 0);
      step();
      check("tbl_idle_busy", 32'(busy), 0);
      check("tbl_idle_en",   32'(bus_enable), 0);
    end

    // Contention: req1 (5A) and req3 (FF) held until acked
    do_reset();
    req = 4'b1010; req_data = 32'hFF005A00;
    n_seen = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (ack != '0) begin
        if (n_seen < 4) begin
          ack_seen[n_seen] = ack; word_seen[n_seen] = unsync_bus; cyc_seen[n_seen] = c;
        end
        n_seen++;
        req = req & ~ack;
      end
    end
    check("cont_nacks", n_seen, 2);
    if (n_seen >= 2) begin
      check("cont_ack0",  32'(ack_seen[0]), 32'b0010);
      check("cont_word0", 32'(word_seen[0]), 32'h5A);
      check("cont_ack1",  32'(ack_seen[1]), 32'b1000);
      check("cont_word1", 32'(word_seen[1]), 32'hFF);
      check("cont_spacing", cyc_seen[1] - cyc_seen[0], 7);
    end

    // Reset in the 2nd HOLD cycle of 3C (req2), then req0+req3 pending
    req = 4'b0100; req_data = 32'h003C0000;
    step();
    check("rmh_grant_bus", 32'(unsync_bus), 32'h3C);
    step();
    rst_n = 1'b0;
    #1;
    check("rmh_en",   32'(bus_enable), 0);
    check("rmh_bus",  32'(unsync_bus), 0);
    check("rmh_ack",  32'(ack), 0);
    check("rmh_busy", 32'(busy), 0);
    check("rmh_gid",  32'(grant_id), 0);
    req = 4'b1001; req_data = 32'h03000001;
    step();
    check("rmh_noack", 32'(ack), 0);
    rst_n = 1'b1;
    step();
    check("rmh_regrant_gid", 32'(grant_id), 0);
    check("rmh_regrant_bus", 32'(unsync_bus), 32'h01);
    req = '0;
    repeat (H + G + 1) step();

    // Fairness: all requesters continuously requesting
    do_reset();
    req = 4'b1111; req_data = 32'h44332211;
    n_seen = 0; run = 0; max_run = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      run = bus_enable ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (ack != '0) begin
        check("fair_onehot", 32'($onehot(ack)), 1);
        if (n_seen < 8) order[n_seen] = int'(grant_id);
        n_seen++;
      end
    end
    check("fair_nacks", 32'(n_seen >= 6), 1);
    if (n_seen >= 6) begin
      for (int i = 0; i < 6; i++) check("fair_order", order[i], exp_order[i]);
    end
    check("fair_max_en_run", max_run, H);
    req = '0;
    repeat (H + G + 1) step();

    // Minimum HOLD/GAP instance: 1 cycle enable, ack next, 3-cycle period
    req_b = 4'b0001; req_data_b = 32'h00000077;
    for (int i = 0; i < 5 && !bus_enable_b; i++) step();
    check("min_en",  32'(bus_enable_b), 1);
    check("min_bus", 32'(unsync_bus_b), 32'h77);
    step();
    check("min_en_low", 32'(bus_enable_b), 0);
    check("min_ack",    32'(ack_b), 32'b0001);
    step();
    check("min_gap_ack",  32'(ack_b), 0);
    check("min_gap_en",   32'(bus_enable_b), 0);
    check("min_idle_busy", 32'(busy_b), 0);
    step();
    check("min_period_en", 32'(bus_enable_b), 1);
    req_b = '0;

    // Randomized run against the reference model, with occasional resets
    do_reset();
    model_reset();
    model_on = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_model("rand_rst");
      end
      req      = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom_range(1, 15));
      req_data = $urandom;
      step();
      compare_model("rand");
    end
    model_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
